// File: rtl/ula_op_sequencer.sv
// rtl/ula_op_sequencer.sv - pops operands, drives the ALU selects and pushes the result for one opcode
// Handshakes with the data stack are bounded by TIMEOUT; an expired wait sets the sticky ERR flag.
module ula_op_sequencer #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       OP_VALID,
   input  logic [3:0] OP_CODE,
   output logic       OP_READY,
   output logic       POP_REQ,
   input  logic       POP_ACK,
   output logic       PUSH_REQ,
   input  logic       PUSH_ACK,
   output logic [1:0] SEL_MUX1,
   output logic [1:0] SEL_MUX2,
   output logic [3:0] SEL_ULA,
   output logic       CTRL_REG_OP1,
   output logic       CTRL_REG_OP2,
   output logic       CTRL_REG_COMP,
   output logic       CTRL_REG_OVERFLOW,
   output logic       DONE,
   output logic       ERR
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_POP1 = 3'd1;
   localparam logic [2:0] S_POP2 = 3'd2;
   localparam logic [2:0] S_EXEC = 3'd3;
   localparam logic [2:0] S_PUSH = 3'd4;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [3:0] op_q;
   logic [7:0] wait_cnt;
   logic       ready_q;
   logic       err_q;
   logic       err_nxt;
   logic       accept;

   logic       cls_c;
   logic       cls_u1;
   logic       cls_u2;
   logic       single_pop;
   logic       uses_ovf;
   logic       timed_out;

   // Opcode classes, decoded from the latched opcode so they stay valid for the whole operation.
   assign cls_c      = (op_q >= 4'd9) && (op_q <= 4'd11);
   assign cls_u2     = (op_q >= 4'd5) && (op_q <= 4'd8);
   assign cls_u1     = (op_q == 4'd4) || (op_q == 4'd12);
   assign single_pop = cls_u1 || cls_u2;
   assign uses_ovf   = (op_q <= 4'd2);
   assign timed_out  = (wait_cnt == WAIT_LAST);

   assign accept   = OP_VALID && ready_q;
   assign OP_READY = ready_q;
   assign ERR      = err_q;

   always_comb begin
      state_nxt         = state;
      err_nxt           = err_q;
      POP_REQ           = 1'b0;
      PUSH_REQ          = 1'b0;
      SEL_MUX1          = 2'b00;
      SEL_MUX2          = 2'b00;
      SEL_ULA           = 4'd0;
      CTRL_REG_OP1      = 1'b0;
      CTRL_REG_OP2      = 1'b0;
      CTRL_REG_COMP     = 1'b0;
      CTRL_REG_OVERFLOW = 1'b0;
      DONE              = 1'b0;

      if (state == S_EXEC || state == S_PUSH) begin
         SEL_ULA  = op_q;
         SEL_MUX1 = cls_u2 ? 2'b00 : 2'b11;
         SEL_MUX2 = cls_u1 ? 2'b00 : 2'b11;
      end

      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_POP1;
               err_nxt   = 1'b0;
            end
         end
         S_POP1: begin
            POP_REQ = 1'b1;
            // The ACK is checked before the timeout so a late ACK still completes the pop.
            if (POP_ACK) begin
               CTRL_REG_OP1 = !cls_u2;
               CTRL_REG_OP2 = cls_u2;
               state_nxt    = single_pop ? S_EXEC : S_POP2;
            end else if (timed_out) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         S_POP2: begin
            POP_REQ = 1'b1;
            if (POP_ACK) begin
               CTRL_REG_OP2 = 1'b1;
               state_nxt    = S_EXEC;
            end else if (timed_out) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         S_EXEC: begin
            CTRL_REG_OVERFLOW = uses_ovf;
            CTRL_REG_COMP     = cls_c;
            if (cls_c) begin
               DONE      = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_PUSH;
            end
         end
         S_PUSH: begin
            PUSH_REQ = 1'b1;
            if (PUSH_ACK) begin
               DONE      = 1'b1;
               state_nxt = S_IDLE;
            end else if (timed_out) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op_q     <= 4'd0;
         wait_cnt <= 8'd0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == S_IDLE);
         err_q   <= err_nxt;
         if (accept) begin
            op_q <= OP_CODE;
         end
         // Any state change restarts the wait, which covers every entry to POP1, POP2 and PUSH.
         if (state_nxt != state || state == S_IDLE || state == S_EXEC) begin
            wait_cnt <= 8'd0;
         end else begin
            wait_cnt <= wait_cnt + 8'd1;
         end
      end
   end

endmodule

// File: doc/ula_op_sequencer.md
ULA_OP_SEQUENCER -- requirements
Module: ula_op_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum cycles spent waiting for POP_ACK or PUSH_ACK (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 OP_VALID  input  1  opcode offered.
REQ-005 OP_CODE  input  4  ALU operation, same encoding as the SEL_ULA input of the ALU block.
REQ-006 OP_READY  output  1  sequencer can accept an opcode.
REQ-007 POP_REQ  output  1  request one operand from the data stack onto the ALU REG1_IN bus.
REQ-008 POP_ACK  input  1  operand valid on the bus this cycle.
REQ-009 PUSH_REQ  output  1  ULA_OUT is valid to push.
REQ-010 PUSH_ACK  input  1  result taken this cycle.
REQ-011 SEL_MUX1  output  2  ALU IN_1 select: 00 zero, 01 one, 10 jump, 11 regOp1.
REQ-012 SEL_MUX2  output  2  ALU IN_2 select: 00 pc, 01 tos, 10 regArg, 11 regOp2.
REQ-013 SEL_ULA  output  4  ALU operation select.
REQ-014 CTRL_REG_OP1, CTRL_REG_OP2, CTRL_REG_COMP, CTRL_REG_OVERFLOW  output  1 each  ALU register load enables.
REQ-015 DONE  output  1  one-cycle pulse when an operation completes.
REQ-016 ERR  output  1  sticky timeout flag.

Function
REQ-017 Opcode classes SHALL be:
- B (two pops): 0000-0011, 1101-1111.
- C (two pops, no push): 1001-1011.
- U2 (one pop into regOp2): 0101, 0110, 0111, 1000.
- U1 (one pop into regOp1): 0100, 1100.
REQ-018 The FSM SHALL have states IDLE, POP1, POP2, EXEC, PUSH.
REQ-019 OP_READY SHALL be a register that is 1 in IDLE and 0 in all other states; it SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-020 An opcode SHALL be accepted on OP_VALID&&OP_READY; OP_CODE SHALL be latched, the ERR flag cleared, and the FSM SHALL move to POP1.
REQ-021 POP1 SHALL hold POP_REQ=1 until POP_ACK. In the ACK cycle it SHALL pulse CTRL_REG_OP1, except for U2, which pulses CTRL_REG_OP2. The next state SHALL be POP2 for B/C and EXEC for U1/U2.
REQ-022 POP2 SHALL hold POP_REQ=1 until POP_ACK and pulse CTRL_REG_OP2 in the ACK cycle, then go to EXEC. The first pop is TOS, so SUB yields second-pop minus TOS.
REQ-023 In EXEC and PUSH:
- SEL_ULA SHALL equal the latched opcode.
- SEL_MUX1 SHALL be 11 for B/C/U1 and 00 for U2.
- SEL_MUX2 SHALL be 11 for B/C/U2 and 00 for U1.
REQ-024 EXEC SHALL last exactly one cycle and pulse CTRL_REG_OVERFLOW for 0000-0010 and CTRL_REG_COMP for class C.
REQ-025 From EXEC, class C SHALL pulse DONE in the EXEC cycle and return to IDLE; all other classes SHALL go to PUSH.
REQ-026 PUSH SHALL hold PUSH_REQ=1 with the selects stable until PUSH_ACK. In the ACK cycle it SHALL pulse DONE, then go to IDLE.
REQ-027 Outside EXEC/PUSH, SEL_ULA, SEL_MUX1 and SEL_MUX2 SHALL be 0. All CTRL_REG_* signals SHALL be 0 except where pulsed above.
REQ-028 A wait counter SHALL clear on every entry to POP1, POP2 and PUSH.
REQ-029 If the counter reaches TIMEOUT-1 without ACK, the block SHALL drop the REQ, set ERR, skip DONE, and return to IDLE.
REQ-030 An ACK that arrives in the timeout cycle SHALL win.
REQ-031 POP_ACK or PUSH_ACK while the matching REQ is 0 SHALL be ignored.
REQ-032 OP_VALID while OP_READY=0 SHALL be ignored, with no queuing.
REQ-033 Zero-wait latency from the accept edge SHALL be:
- B: DONE 4 cycles later.
- C: 3 cycles.
- U1/U2: 3 cycles.

Reset
REQ-034 While rst_n=0, the block SHALL immediately force state IDLE and drive all outputs to 0, including OP_READY, ERR and DONE.
REQ-035 Reset mid-operation SHALL abandon the operation with no DONE, PUSH_REQ or register pulse.

Verification
REQ-036 OP_CODE=0001 with acks immediate:
- POP1 cycle: CTRL_REG_OP1.
- POP2 cycle: CTRL_REG_OP2.
- EXEC: SEL_ULA=0001, muxes 11/11, CTRL_REG_OVERFLOW=1.
- PUSH: PUSH_REQ, DONE at accept+4.
REQ-037 OP_CODE=1010 -> two pops, EXEC CTRL_REG_COMP=1, DONE at accept+3, PUSH_REQ never 1.
REQ-038 OP_CODE=0110 -> single pop pulses CTRL_REG_OP2; EXEC SEL_MUX1=00, SEL_MUX2=11, SEL_ULA=0110; push; DONE at accept+3.
REQ-039 TIMEOUT=4 with POP_ACK never asserted -> POP_REQ high 4 cycles, then ERR=1, OP_READY=1, DONE never; next accept clears ERR.
REQ-040 PUSH_ACK delayed 3 cycles -> PUSH_REQ and SEL_* stable for 4 cycles, single DONE in the ACK cycle.
REQ-041 rst_n low during POP2 -> all outputs 0 immediately; after release OP_READY=1 one edge later and a new opcode completes normally.
